// File: rtl/blake2b_core.sv
// Iterative unkeyed BLAKE2b compression/finalization engine with truncated digest output.
// Optional macro BLAKE2_FULL_ROUND_EN: eight G units, one full round per cycle (14-cycle latency).
module blake2b_core #(
  parameter int DIGEST_LENGTH = 64
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          init,
  input  logic          next,
  input  logic          final_block,
  input  logic [1023:0] block,
  input  logic [127:0]  data_length,
  output logic          ready,
  output logic [511:0]  digest,
  output logic          digest_valid,
  output logic [1:0]    o_dbg_state
);

  localparam logic [63:0] IV0 = 64'h6a09e667f3bcc908;
  localparam logic [63:0] IV1 = 64'hbb67ae8584caa73b;
  localparam logic [63:0] IV2 = 64'h3c6ef372fe94f82b;
  localparam logic [63:0] IV3 = 64'ha54ff53a5f1d36f1;
  localparam logic [63:0] IV4 = 64'h510e527fade682d1;
  localparam logic [63:0] IV5 = 64'h9b05688c2b3e6c1f;
  localparam logic [63:0] IV6 = 64'h1f83d9abfb41bd6b;
  localparam logic [63:0] IV7 = 64'h5be0cd19137e2179;

  // Word k of every packed state vector lives at [64k +: 64].
  localparam logic [511:0] IV_VEC = {IV7, IV6, IV5, IV4, IV3, IV2, IV1, IV0};
  localparam logic [63:0]  P0     = 64'h0101_0000 ^ 64'(DIGEST_LENGTH);
  localparam logic [511:0] H_INIT = IV_VEC ^ {448'b0, P0};

`ifdef BLAKE2_FULL_ROUND_EN
  localparam logic [4:0] LAST_STEP = 5'd11;
`else
  localparam logic [4:0] LAST_STEP = 5'd23;
`endif

  function automatic logic [511:0] digest_mask();
    logic [511:0] msk;
    msk = '0;
    for (int j = 0; j < 64; j++) begin
      msk[511-8*j -: 8] = (j < DIGEST_LENGTH) ? 8'hff : 8'h00;
    end
    return msk;
  endfunction

  localparam logic [511:0] DIGEST_MASK = digest_mask();

  function automatic logic [63:0] bswap64(input logic [63:0] w);
    logic [63:0] o;
    for (int b = 0; b < 8; b++) begin
      o[8*b +: 8] = w[63-8*b -: 8];
    end
    return o;
  endfunction

  // Message permutation; entry k of a row sits in nibble [63-4k -: 4].
  function automatic logic [63:0] sigma_row(input logic [3:0] r);
    logic [63:0] s;
    case (r)
      4'd0, 4'd10: s = 64'h0123456789abcdef;
      4'd1, 4'd11: s = 64'hea489fd61c02b753;
      4'd2:        s = 64'hb8c052fdae367194;
      4'd3:        s = 64'h7931dcbe265a40f8;
      4'd4:        s = 64'h905724afe1bc683d;
      4'd5:        s = 64'h2c6a0b834d75fe19;
      4'd6:        s = 64'hc51fed4a0763928b;
      4'd7:        s = 64'hdb7ec13950f4862a;
      4'd8:        s = 64'h6fe9b308c2d714a5;
      4'd9:        s = 64'ha2847615fb9e3cd0;
      default:     s = 64'h0123456789abcdef;
    endcase
    return s;
  endfunction

  function automatic logic [255:0] g_fn(input logic [63:0] a, input logic [63:0] b,
                                        input logic [63:0] c, input logic [63:0] d,
                                        input logic [63:0] x, input logic [63:0] y);
    logic [63:0] a1, b1, c1, d1, t;
    a1 = a + b + x;
    t  = d ^ a1;
    d1 = {t[31:0], t[63:32]};
    c1 = c + d1;
    t  = b ^ c1;
    b1 = {t[23:0], t[63:24]};
    a1 = a1 + b1 + y;
    t  = d1 ^ a1;
    d1 = {t[15:0], t[63:16]};
    c1 = c1 + d1;
    t  = b1 ^ c1;
    b1 = {t[62:0], t[63]};
    return {a1, b1, c1, d1};
  endfunction

  // One column step (diag = 0) or diagonal step (diag = 1): four independent G functions.
  function automatic logic [1023:0] half_round(input logic [1023:0] v, input logic [63:0] sig,
                                               input logic diag, input logic [1023:0] m);
    logic [1023:0] r;
    logic [255:0]  g;
    logic [3:0]    xi, yi;
    int            ia, ib, ic, id, p, sh;
    r  = v;
    sh = diag ? 1 : 0;
    for (int i = 0; i < 4; i++) begin
      ia = i;
      ib = 4 + ((i + sh) % 4);
      ic = 8 + ((i + 2 * sh) % 4);
      id = 12 + ((i + 3 * sh) % 4);
      p  = 2 * i + 8 * sh;
      xi = sig[63-4*p -: 4];
      yi = sig[59-4*p -: 4];
      g  = g_fn(r[64*ia +: 64], r[64*ib +: 64], r[64*ic +: 64], r[64*id +: 64],
                m[64*xi +: 64], m[64*yi +: 64]);
      r[64*ia +: 64] = g[255:192];
      r[64*ib +: 64] = g[191:128];
      r[64*ic +: 64] = g[127:64];
      r[64*id +: 64] = g[63:0];
    end
    return r;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_INIT   = 2'd1,
    ST_ROUND  = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  state_t         r_state, w_state_next;
  logic [511:0]   r_h;
  logic [1023:0]  r_v;
  logic [1023:0]  r_m;
  logic [127:0]   r_t;
  logic           r_final;
  logic [4:0]     r_step;
  logic [511:0]   r_digest;
  logic           r_valid;

  logic           w_cmd, w_start;
  logic [1023:0]  w_m, w_v_init, w_v_next;
  logic [63:0]    w_sig;
  logic [511:0]   w_h_new, w_digest_new;

  // Handshake: a command is taken on any rising edge where ready is high and at
  // least one of init/next/final_block is high; otherwise those inputs are ignored.
  assign ready       = (r_state == ST_IDLE);
  assign w_cmd       = ready & (init | next | final_block);
  assign w_start     = ready & (next | final_block);
  assign digest      = r_digest;
  assign digest_valid = r_valid;
  assign o_dbg_state = r_state;

  always_comb begin
    w_m = '0;
    for (int i = 0; i < 16; i++) begin
      w_m[64*i +: 64] = bswap64(block[1023-64*i -: 64]);
    end
  end

  assign w_v_init = {IV7, IV6 ^ {64{r_final}}, IV5 ^ r_t[127:64], IV4 ^ r_t[63:0],
                     IV3, IV2, IV1, IV0, r_h};

`ifdef BLAKE2_FULL_ROUND_EN
  assign w_sig    = sigma_row(r_step[3:0]);
  assign w_v_next = half_round(half_round(r_v, w_sig, 1'b0, r_m), w_sig, 1'b1, r_m);
`else
  assign w_sig    = sigma_row(r_step[4:1]);
  assign w_v_next = half_round(r_v, w_sig, r_step[0], r_m);
`endif

  assign w_h_new = r_h ^ r_v[511:0] ^ r_v[1023:512];

  always_comb begin
    w_digest_new = '0;
    for (int k = 0; k < 8; k++) begin
      w_digest_new[511-64*k -: 64] = bswap64(w_h_new[64*k +: 64]);
    end
    w_digest_new = w_digest_new & DIGEST_MASK;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_start) w_state_next = ST_INIT;
      ST_INIT:   w_state_next = ST_ROUND;
      ST_ROUND:  if (r_step == LAST_STEP) w_state_next = ST_FINISH;
      ST_FINISH: w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_h      <= '0;
      r_v      <= '0;
      r_m      <= '0;
      r_t      <= '0;
      r_final  <= 1'b0;
      r_step   <= '0;
      r_digest <= '0;
      r_valid  <= 1'b0;
    end else begin
      if (w_cmd) r_valid <= 1'b0;
      if (ready && init) r_h <= H_INIT;
      if (w_start) begin
        r_m     <= w_m;
        r_t     <= data_length;
        r_final <= final_block;
        r_step  <= '0;
      end
      case (r_state)
        ST_INIT: r_v <= w_v_init;
        ST_ROUND: begin
          r_v    <= w_v_next;
          r_step <= r_step + 5'd1;
        end
        ST_FINISH: begin
          r_h      <= w_h_new;
          r_digest <= w_digest_new;
          r_valid  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_blake2b_core.sv
// Self-checking bench for blake2b_core: known-answer table, reference model and multi-cycle corner sequences.
module tb_blake2b_core;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          init = 1'b0;
  logic          nxt = 1'b0;
  logic          final_block = 1'b0;
  logic [1023:0] block = '0;
  logic [127:0]  data_length = '0;
  logic          ready64, valid64, ready32, valid32;
  logic [511:0]  digest64, digest32;
  logic [1:0]    st64, st32;

`ifdef BLAKE2_FULL_ROUND_EN
  localparam int LAT = 14;
`else
  localparam int LAT = 26;
`endif

  localparam logic [511:0] EMPTY512 = 512'h786a02f742015903c6c6fd852552d272912f4740e15847618a86e217f71f5419d25e1031afee585313896444934eb04b903a685b1448b755d56f701afe9be2ce;
  localparam logic [511:0] ABC512 = 512'hba80a53f981c4d0d6a2797b69f12f6e94c212f14685ac4b74b12bb6fdbffa2d17d87c5392aab792dc252d5de4533cc9518d38aa8dbf1925ab92386edd4009923;
  localparam logic [511:0] EMPTY256 = {256'h0e5751c026e543b2e8ab2eb06099daa1d1e5df47778f7787faab45cdf12fe3a8, 256'h0};
  localparam logic [1023:0] ABC_BLK = {24'h616263, 1000'h0};

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  blake2b_core #(.DIGEST_LENGTH(64)) u_dut64 (
    .clk(clk), .reset_n(reset_n), .init(init), .next(nxt), .final_block(final_block),
    .block(block), .data_length(data_length), .ready(ready64), .digest(digest64),
    .digest_valid(valid64), .o_dbg_state(st64)
  );

  blake2b_core #(.DIGEST_LENGTH(32)) u_dut32 (
    .clk(clk), .reset_n(reset_n), .init(init), .next(nxt), .final_block(final_block),
    .block(block), .data_length(data_length), .ready(ready32), .digest(digest32),
    .digest_valid(valid32), .o_dbg_state(st32)
  );

  // ---------------- reference model ----------------
  logic [63:0] iv_m [8] = '{64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b,
                            64'ha54ff53a5f1d36f1, 64'h510e527fade682d1, 64'h9b05688c2b3e6c1f,
                            64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};
  int sig_m [10][16] = '{
    '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15},
    '{14, 10, 4, 8, 9, 15, 13, 6, 1, 12, 0, 2, 11, 7, 5, 3},
    '{11, 8, 12, 0, 5, 2, 15, 13, 10, 14, 3, 6, 7, 1, 9, 4},
    '{7, 9, 3, 1, 13, 12, 11, 14, 2, 6, 5, 10, 4, 0, 15, 8},
    '{9, 0, 5, 7, 2, 4, 10, 15, 14, 1, 11, 12, 6, 8, 3, 13},
    '{2, 12, 6, 10, 0, 11, 8, 3, 4, 13, 7, 5, 15, 14, 1, 9},
    '{12, 5, 1, 15, 14, 13, 4, 10, 0, 7, 6, 3, 9, 2, 8, 11},
    '{13, 11, 7, 14, 12, 1, 3, 9, 5, 0, 15, 4, 8, 6, 2, 10},
    '{6, 15, 14, 9, 11, 3, 0, 8, 12, 2, 13, 7, 1, 4, 10, 5},
    '{10, 2, 8, 4, 7, 6, 1, 5, 15, 11, 9, 14, 3, 12, 13, 0}};

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [63:0] bswap(input logic [63:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24], x[39:32], x[47:40], x[55:48], x[63:56]};
  endfunction

  function automatic logic [511:0] model_h0(input int dl);
    logic [511:0] h;
    for (int i = 0; i < 8; i++) h[64*i +: 64] = iv_m[i];
    h[63:0] = h[63:0] ^ 64'h0101_0000 ^ 64'(dl);
    return h;
  endfunction

  function automatic logic [511:0] model_compress(input logic [511:0] h, input logic [1023:0] blk,
                                                  input logic [127:0] t, input logic fin);
    logic [63:0]  v [16];
    logic [63:0]  m [16];
    logic [63:0]  x, y;
    logic [511:0] hn;
    int ga [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int gb [8] = '{4, 5, 6, 7, 5, 6, 7, 4};
    int gc [8] = '{8, 9, 10, 11, 10, 11, 8, 9};
    int gd [8] = '{12, 13, 14, 15, 15, 12, 13, 14};
    int a, b, c, d;
    for (int i = 0; i < 16; i++) m[i] = bswap(blk[1023-64*i -: 64]);
    for (int i = 0; i < 8; i++) begin
      v[i]     = h[64*i +: 64];
      v[i + 8] = iv_m[i];
    end
    v[12] = v[12] ^ t[63:0];
    v[13] = v[13] ^ t[127:64];
    if (fin) v[14] = ~v[14];
    for (int r = 0; r < 12; r++) begin
      for (int g = 0; g < 8; g++) begin
        a = ga[g]; b = gb[g]; c = gc[g]; d = gd[g];
        x = m[sig_m[r % 10][2*g]];
        y = m[sig_m[r % 10][2*g + 1]];
        v[a] = v[a] + v[b] + x;
        v[d] = rotr(v[d] ^ v[a], 32);
        v[c] = v[c] + v[d];
        v[b] = rotr(v[b] ^ v[c], 24);
        v[a] = v[a] + v[b] + y;
        v[d] = rotr(v[d] ^ v[a], 16);
        v[c] = v[c] + v[d];
        v[b] = rotr(v[b] ^ v[c], 63);
      end
    end
    for (int i = 0; i < 8; i++) hn[64*i +: 64] = h[64*i +: 64] ^ v[i] ^ v[i + 8];
    return hn;
  endfunction

  function automatic logic [511:0] model_digest(input logic [511:0] h, input int dl);
    logic [511:0] dg;
    dg = '0;
    for (int j = 0; j < 64; j++) begin
      if (j < dl) dg[511-8*j -: 8] = h[64*(j/8) + 8*(j%8) +: 8];
    end
    return dg;
  endfunction

  // ---------------- scoreboard ----------------
  logic [511:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int accept_cyc = 0;

  task automatic check_vec(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic send(input logic a_init, input logic a_next, input logic a_fin,
                      input logic [1023:0] a_blk, input logic [127:0] a_len);
    int guard;
    guard = 0;
    while (ready64 !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check_int("send_ready", int'(ready64 === 1'b1), 1);
    init = a_init;
    nxt = a_next;
    final_block = a_fin;
    block = a_blk;
    data_length = a_len;
    @(posedge clk);
    #1;
    init = 1'b0;
    nxt = 1'b0;
    final_block = 1'b0;
    accept_cyc = cyc;
  endtask

  task automatic wait_done(input string name, input logic pulse);
    int n, early;
    logic [511:0] exp;
    n = 0;
    early = 0;
    while (valid64 !== 1'b1 && n < 3 * LAT) begin
      if (ready64 !== 1'b0) early++;
      @(negedge clk);
      n++;
      if (pulse && (n == 5 || n == LAT - 6)) begin
        init = 1'b1;
        nxt = 1'b1;
        block = {32{$urandom()}};
        data_length = {4{$urandom()}};
      end else begin
        init = 1'b0;
        nxt = 1'b0;
      end
    end
    init = 1'b0;
    nxt = 1'b0;
    check_int({name, "_latency"}, cyc - accept_cyc, LAT);
    check_int({name, "_ready_low"}, early, 0);
    check_int({name, "_ready_after"}, int'(ready64), 1);
    if (exp_q.size() == 0) begin
      check_int({name, "_queue"}, 0, 1);
    end else begin
      exp = exp_q.pop_front();
      check_vec({name, "_digest"}, digest64, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          i_init;
    logic          i_next;
    logic          i_fin;
    logic [1023:0] blk;
    logic [127:0]  len;
    logic [511:0]  exp64;
    logic          chk32;
    logic [511:0]  exp32;
  } vec_t;

  function automatic vec_t mk(input logic a_init, input logic a_next, input logic a_fin,
                              input logic [1023:0] a_blk, input logic [127:0] a_len,
                              input logic [511:0] a_exp, input logic a_chk32,
                              input logic [511:0] a_exp32);
    vec_t r;
    r.i_init = a_init; r.i_next = a_next; r.i_fin = a_fin;
    r.blk = a_blk; r.len = a_len; r.exp64 = a_exp;
    r.chk32 = a_chk32; r.exp32 = a_exp32;
    return r;
  endfunction

  vec_t tbl [6];

  initial begin
    logic [511:0]  h0, hm1, hm2, hr;
    logic [1023:0] rnd_blk;

    h0  = model_h0(64);
    hm1 = model_compress(h0, '0, 128'd128, 1'b0);
    hm2 = model_compress(hm1, '0, 128'd256, 1'b1);
    for (int k = 0; k < 32; k++) rnd_blk[32*k +: 32] = $urandom();
    hr  = model_compress(h0, rnd_blk, 128'd77, 1'b1);

    tbl[0] = mk(1'b1, 1'b0, 1'b1, '0, 128'd0, EMPTY512, 1'b1, EMPTY256);
    tbl[1] = mk(1'b1, 1'b0, 1'b1, ABC_BLK, 128'd3, ABC512, 1'b0, '0);
    tbl[2] = mk(1'b1, 1'b1, 1'b0, '0, 128'd128, model_digest(hm1, 64), 1'b0, '0);
    tbl[3] = mk(1'b0, 1'b0, 1'b1, '0, 128'd256, model_digest(hm2, 64), 1'b0, '0);
    tbl[4] = mk(1'b1, 1'b1, 1'b1, ABC_BLK, 128'd3, ABC512, 1'b0, '0);
    tbl[5] = mk(1'b1, 1'b0, 1'b1, rnd_blk, 128'd77, model_digest(hr, 64), 1'b0, '0);

    // Reset state.
    repeat (2) @(negedge clk);
    check_int("rst_ready", int'(ready64), 1);
    check_int("rst_valid", int'(valid64), 0);
    check_vec("rst_digest64", digest64, '0);
    check_vec("rst_digest32", digest32, '0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      send(tbl[i].i_init, tbl[i].i_next, tbl[i].i_fin, tbl[i].blk, tbl[i].len);
      exp_q.push_back(tbl[i].exp64);
      wait_done($sformatf("vec%0d", i), 1'b0);
      if (tbl[i].chk32) check_vec($sformatf("vec%0d_digest32", i), digest32, tbl[i].exp32);
      @(negedge clk);
    end

    // init alone: single-cycle reload, clears digest_valid, then a bare final_block continues from IV.
    send(1'b1, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check_int("init_only_ready", int'(ready64), 1);
    check_int("init_only_valid", int'(valid64), 0);
    send(1'b0, 1'b0, 1'b1, ABC_BLK, 128'd3);
    exp_q.push_back(ABC512);
    wait_done("after_init_only", 1'b0);

    // Commands pulsed while busy are ignored; block/length changes after acceptance are too.
    @(negedge clk);
    send(1'b1, 1'b0, 1'b1, ABC_BLK, 128'd3);
    exp_q.push_back(ABC512);
    wait_done("busy", 1'b1);
    repeat (30) @(negedge clk);
    check_int("busy_hold_ready", int'(ready64), 1);
    check_int("busy_hold_valid", int'(valid64), 1);
    check_vec("busy_hold_digest", digest64, ABC512);

    // Reset in the middle of a compression.
    send(1'b1, 1'b0, 1'b1, ABC_BLK, 128'd3);
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_int("midrst_ready", int'(ready64), 1);
    check_int("midrst_valid", int'(valid64), 0);
    check_vec("midrst_digest", digest64, '0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    send(1'b1, 1'b0, 1'b1, ABC_BLK, 128'd3);
    exp_q.push_back(ABC512);
    wait_done("post_reset_abc", 1'b0);

    check_int("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/blake2b_core.md
# blake2b_core

Iterative BLAKE2b compression-and-finalization engine, unkeyed, with configurable digest length. It accepts one 1024-bit message block per command, keeps the 512-bit chaining state internally, and presents the (truncated) hash value when a compression finishes. It sits below the host-side block/padding controller, which supplies padded blocks and running byte counts.

## Interface
- DIGEST_LENGTH, default 64: digest length in bytes (1..64); enters parameter word p[0] = 0x0101_0000 ^ DIGEST_LENGTH.
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- init  in  1  start a new hash; reload the chaining state.
- next  in  1  compress `block` as a non-final block.
- final_block  in  1  compress `block` as the last block (final flag f0 = all ones).
- block  in  1024  message block; message byte 0 = block[1023:1016]; word m[i] = little-endian bytes 8i..8i+7.
- data_length  in  128  byte counter t after this block (t0 = [63:0], t1 = [127:64]).
- ready  out  1  high when idle and able to accept a command.
- digest  out  512  hash output; output byte j = block-style byte j at digest[511-8j -: 8] (little-endian from h words); bytes ≥ DIGEST_LENGTH forced to 0.
- digest_valid  out  1  high when `digest` holds the result of the last completed compression.

## Operation
- Chaining state h[0..7]; IV = standard BLAKE2b IV; init sets h = IV with h[0] ^= p[0].
- Commands sampled only when ready = 1; while busy, init/next/final_block ignored.
- init alone: h reloaded, digest_valid cleared, ready stays 1 (single-cycle).
- init with next or final_block in same cycle: h reloaded first, then the block is compressed from the fresh state.
- next and final_block together: treated as final_block.
- Compression: v[0..7] = h, v[8..15] = IV, v[12] ^= t0, v[13] ^= t1, v[14] ^= final ? all-ones : 0; 12 rounds with standard sigma schedule (rounds 10, 11 reuse sigma 0, 1); G with rotations 32, 24, 16, 63, 64-bit modulo-2^64 adds.
- Each round = column step (4 G) then diagonal step (4 G); one step per cycle.
- Finish: h[i] ^= v[i] ^ v[i+8]; digest register updated from new h (truncated); digest_valid set for both next and final_block completions.
- States: IDLE → INIT (load v) → ROUND (24 steps) → FINISH → IDLE.

## Timing
- Reset values: ready = 1, digest_valid = 0, digest = 0, h = 0, state IDLE.
- Command accepted at edge E0: ready and digest_valid drop after E0.
- E1 loads v; E2..E25 execute 24 G-steps; E26 performs finish: ready = 1, digest_valid = 1 visible after E26 (latency 26 cycles).
- digest/digest_valid hold until the next accepted command (cleared after its acceptance edge).
- Reset asserted mid-compression aborts immediately to reset values; no partial digest.
- data_length sampled only at acceptance edge; block may change afterwards (latched at E0).

## Configuration
- BLAKE2_FULL_ROUND_EN: when defined, 8 G functions instantiated and a full round (column + diagonal) completes per cycle; ROUND lasts 12 cycles, latency 14 cycles (finish at E14). When undefined, 4-G datapath, latency 26 cycles as above. Results identical.

## Test plan
- Empty message: init+final_block, block = 0, data_length = 0, DIGEST_LENGTH = 64 → digest = 786a02f742015903c6c6fd852552d272912f4740e15847618a86e217f71f5419d25e1031afee585313896444934eb04b903a685b1448b755d56f701afe9be2ce, digest_valid rises exactly 26 cycles after acceptance.
- "abc": block bytes 61 62 63 then zeros, data_length = 3, init+final_block → digest = ba80a53f981c4d0d6a2797b69f12f6e94c212f14685ac4b74b12bb6fdbffa2d17d87c5392aab792dc252d5de4533cc9518d38aa8dbf1925ab92386edd4009923.
- Two blocks of zeros: init+next (data_length 128) then final_block (data_length 256) → digest_valid after each (26 cycles each), final digest matches software BLAKE2b-512 of 256 zero bytes.
- Busy protection: pulse next/init at cycles 5 and 20 of a compression → no effect; "abc" result unchanged, ready low throughout.
- Reset at cycle 10 of a compression → ready = 1, digest_valid = 0, digest = 0 immediately; subsequent "abc" run correct.
- DIGEST_LENGTH = 32, empty message → first 32 bytes equal BLAKE2b-256 of empty string (0e5751c026e543b2e8ab2eb06099daa1d1e5df47778f7787faab45cdf12fe3a8), remaining 32 bytes zero.
